ro_pair_measure: RTL
====================

RO_PAIR_MEASURE -- requirements
Module: ro_pair_measure

Interface
REQ-001 Parameter NUM_BITS, default 32, width of each counter value input and of the difference output.
REQ-002 Parameter CLR_CYCLES, default 4, number of cycles counter_arst is held in the CLEAR state; legal range >=1.
REQ-003 Parameter WINDOW_CYCLES, default 1024, number of cycles counter_enable is held high; legal range >=1.
REQ-004 Parameter SETTLE_CYCLES, default 4, number of idle cycles after the window before sampling, so ripple carries settle; legal range >=1.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 arst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  request one measurement; sampled only in IDLE.
REQ-008 count_a  input  NUM_BITS  binary count from ring-oscillator counter A.
REQ-009 count_b  input  NUM_BITS  binary count from ring-oscillator counter B.
REQ-010 counter_arst  output  1  active-high asynchronous clear, driven to both counters.
REQ-011 counter_enable  output  1  count enable, driven to both counters.
REQ-012 busy  output  1  high in every state other than IDLE.
REQ-013 response  output  1  PUF bit: 1 if count_a > count_b, else 0.
REQ-014 tie  output  1  1 if count_a == count_b.
REQ-015 diff  output  NUM_BITS  unsigned |count_a - count_b|.
REQ-016 response_valid  output  1  one-cycle pulse marking new response/tie/diff.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, COUNT, SETTLE, SAMPLE, DONE; all outputs SHALL be registered.
REQ-018 IDLE: counter_arst=1, counter_enable=0; on rising clk with start=1, go to CLEAR.
REQ-019 CLEAR: counter_arst=1, counter_enable=0 for exactly CLR_CYCLES cycles, then COUNT.
REQ-020 COUNT: counter_arst=0, counter_enable=1 for exactly WINDOW_CYCLES cycles, then SETTLE.
REQ-021 SETTLE: counter_arst=0, counter_enable=0 for exactly SETTLE_CYCLES cycles, then SAMPLE.
REQ-022 SAMPLE (1 cycle): capture count_a and count_b into internal registers; counter_arst=0, counter_enable=0.
REQ-023 DONE (1 cycle): response, tie, and diff SHALL be updated from the captured values; response_valid=1; next state IDLE.
REQ-024 Latency from the clk edge sampling start=1 to the response_valid cycle SHALL be CLR_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES+2 cycles.
REQ-025 start SHALL be ignored while busy=1; start held high SHALL begin a new measurement on the cycle after DONE returns to IDLE.
REQ-026 response, tie, and diff SHALL hold their last values until the next DONE.
REQ-027 Comparison SHALL be unsigned on the full NUM_BITS; counter wrap-around is not detected and the wrapped values are compared as-is.
REQ-028 diff SHALL be computed without overflow: diff=count_a-count_b if count_a>=count_b, else count_b-count_a.
REQ-029 Phase counter width SHALL be $clog2 of max(CLR_CYCLES, WINDOW_CYCLES, SETTLE_CYCLES)+1; it SHALL reset to 0 on every state entry.
REQ-030 count_a and count_b SHALL be read only in SAMPLE; their values in other states SHALL have no effect on any output.

Reset
REQ-031 While arst_n=0, regardless of clk: state=IDLE, counter_arst=1, counter_enable=0, busy=0, response=0, tie=0, diff=0, response_valid=0, phase counter=0.
REQ-032 Assertion of arst_n mid-measurement SHALL abort it immediately with no response_valid pulse; release SHALL resume in IDLE.
REQ-033 The first start is accepted on the first rising clk after arst_n deasserts.

Verification
REQ-034 Defaults; start pulse; count_a=5000, count_b=4990 at SAMPLE -> response_valid exactly 1034 cycles after start; response=1, tie=0, diff=10.
REQ-035 count_a=100, count_b=300 -> response=0, tie=0, diff=200; count_a=count_b=777 -> response=0, tie=1, diff=0.
REQ-036 NUM_BITS=32, count_a=0x00000001, count_b=0xFFFFFFFF -> response=0, diff=0xFFFFFFFE, no overflow.
REQ-037 Check waveform: counter_arst high for 4 cycles after start, counter_enable high exactly 1024 cycles, both low for 4 settle cycles; start pulses during busy -> no extra measurement.
REQ-038 arst_n pulsed low during COUNT at cycle 500 -> counter_enable=0, counter_arst=1, busy=0 asynchronously; no response_valid; following start completes normally.
REQ-039 start held high continuously -> back-to-back measurements, one response_valid every 1035 cycles.

Source files
------------

// File: rtl/ro_pair_measure.sv
// Ring-oscillator pair measurement sequencer.
// Clears both RO counters, lets them run for a fixed window, waits for the
// ripple carries to settle, then samples and compares the two counts. The
// comparison produces a PUF response bit, a tie flag and the absolute
// difference.
module ro_pair_measure #(
    parameter int unsigned NUM_BITS      = 32,
    parameter int unsigned CLR_CYCLES    = 4,
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                start,
    input  logic [NUM_BITS-1:0] count_a,
    input  logic [NUM_BITS-1:0] count_b,
    output logic                counter_arst,
    output logic                counter_enable,
    output logic                busy,
    output logic                response,
    output logic                tie,
    output logic [NUM_BITS-1:0] diff,
    output logic                response_valid
);

    localparam int unsigned MAX_AB = (CLR_CYCLES > WINDOW_CYCLES) ? CLR_CYCLES : WINDOW_CYCLES;
    localparam int unsigned MAX_C  = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int unsigned PW     = $clog2(MAX_C + 1);

    localparam logic [PW-1:0] CLR_LAST    = PW'(CLR_CYCLES - 1);
    localparam logic [PW-1:0] WINDOW_LAST = PW'(WINDOW_CYCLES - 1);
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COUNT,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;

    logic                a_gt_b;
    logic                a_eq_b;
    logic [NUM_BITS-1:0] abs_diff;

    // Unsigned compare and overflow-free magnitude of the live counts.
    always_comb begin
        a_gt_b   = (count_a > count_b);
        a_eq_b   = (count_a == count_b);
        abs_diff = (count_a >= count_b) ? (count_a - count_b) : (count_b - count_a);
    end

    // Next-state selection and phase counter update (phase restarts on every entry).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   if (phase == CLR_LAST) state_next = COUNT;
            COUNT:   if (phase == WINDOW_LAST) state_next = SETTLE;
            SETTLE:  if (phase == SETTLE_LAST) state_next = SAMPLE;
            SAMPLE:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        phase_next = ((state_next != state) || (state == IDLE)) ? '0 : phase + PW'(1);
    end

    // State and phase registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_next;
            phase <= phase_next;
        end
    end

    // Registered outputs, decoded from the state being entered so they line up with it.
    // The counts are sampled on the edge that ends SAMPLE; the result registers
    // themselves hold the captured comparison, visible during DONE and held afterwards.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            counter_arst   <= 1'b1;
            counter_enable <= 1'b0;
            busy           <= 1'b0;
            response_valid <= 1'b0;
            response       <= 1'b0;
            tie            <= 1'b0;
            diff           <= '0;
        end else begin
            counter_arst   <= (state_next == IDLE) || (state_next == CLEAR);
            counter_enable <= (state_next == COUNT);
            busy           <= (state_next != IDLE);
            response_valid <= (state_next == DONE);
            if (state == SAMPLE) begin
                response <= a_gt_b;
                tie      <= a_eq_b;
                diff     <= abs_diff;
            end
        end
    end

endmodule
